// File: rtl/memory_stage_if.sv
// Execute-to-memory bus for memory_stage: e_* stage inputs, pipeline control,
// exported M register and m_* writeback outputs.
interface memory_stage_if;
   logic [3:0]  e_icode;
   logic [3:0]  e_ifun;
   logic        e_Cnd;
   logic [63:0] e_valE;
   logic [63:0] e_valA;
   logic [3:0]  e_dstE;
   logic [3:0]  e_dstM;
   logic [1:0]  e_stat;
   logic        M_bubble;
   logic        wr_block;

   logic [3:0]  M_icode;
   logic [3:0]  M_dstE;
   logic [3:0]  M_dstM;
   logic [63:0] M_valE;
   logic        M_Cnd;
   logic [63:0] m_valM;
   logic [1:0]  m_stat;
   logic [63:0] m_valE;
   logic [3:0]  m_dstE;
   logic [3:0]  m_dstM;
   logic [3:0]  m_icode;

   modport master (
      output e_icode, e_ifun, e_Cnd, e_valE, e_valA, e_dstE, e_dstM, e_stat,
             M_bubble, wr_block,
      input  M_icode, M_dstE, M_dstM, M_valE, M_Cnd,
             m_valM, m_stat, m_valE, m_dstE, m_dstM, m_icode
   );

   modport slave (
      input  e_icode, e_ifun, e_Cnd, e_valE, e_valA, e_dstE, e_dstM, e_stat,
             M_bubble, wr_block,
      output M_icode, M_dstE, M_dstM, M_valE, M_Cnd,
             m_valM, m_stat, m_valE, m_dstE, m_dstM, m_icode
   );
endinterface

// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register plus byte-addressed data memory.
// Define MEM_ADDR_CHECK_EN to flag out-of-range accesses as ADR instead of wrapping.
module memory_stage #(
   parameter int unsigned MEM_BYTES = 1024
) (
   input logic           clk,
   input logic           reset,
   memory_stage_if.slave bus
);
   localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [3:0] R_NONE   = 4'hF;
   localparam logic [1:0] S_AOK    = 2'b00;
   localparam logic [1:0] S_ADR    = 2'b10;

   logic [3:0]  M_icode;
   logic        M_Cnd;
   logic [63:0] M_valE;
   logic [63:0] M_valA;
   logic [3:0]  M_dstE;
   logic [3:0]  M_dstM;
   logic [1:0]  M_stat;

   logic [7:0]    mem [MEM_BYTES] = '{default: 8'h00};
   logic          is_read;
   logic          is_write;
   logic [63:0]   acc_addr;
   logic [AW-1:0] byte_idx [8];
   logic [63:0]   rd_data;
   logic          addr_err;
   logic [1:0]    stat_out;
   logic          wr_en;

   logic unused_ifun;
   assign unused_ifun = ^bus.e_ifun;

   // Reset is asynchronous so a mid-cycle reset turns M into a bubble at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset || bus.M_bubble) begin
         M_icode <= '0;
         M_Cnd   <= 1'b0;
         M_valE  <= '0;
         M_valA  <= '0;
         M_dstE  <= R_NONE;
         M_dstM  <= R_NONE;
         M_stat  <= S_AOK;
      end else begin
         M_icode <= bus.e_icode;
         M_Cnd   <= bus.e_Cnd;
         M_valE  <= bus.e_valE;
         M_valA  <= bus.e_valA;
         M_dstE  <= bus.e_dstE;
         M_dstM  <= bus.e_dstM;
         M_stat  <= bus.e_stat;
      end
   end

   always_comb begin
      is_read  = (M_icode == I_MRMOVQ) || (M_icode == I_POPQ) || (M_icode == I_RET);
      is_write = (M_icode == I_RMMOVQ) || (M_icode == I_PUSHQ) || (M_icode == I_CALL);
      acc_addr = ((M_icode == I_MRMOVQ) || is_write) ? M_valE : M_valA;
      rd_data  = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         byte_idx[i] = AW'((acc_addr + 64'(i)) % 64'(MEM_BYTES));
         rd_data[8*i +: 8] = mem[byte_idx[i]];
      end
   end

`ifdef MEM_ADDR_CHECK_EN
   localparam logic [63:0] LAST_OK = 64'(MEM_BYTES - 8);
   assign addr_err = (is_read || is_write) && (acc_addr > LAST_OK);
`else
   assign addr_err = 1'b0;
`endif

   assign stat_out = addr_err ? S_ADR : M_stat;
   assign wr_en    = is_write && !bus.wr_block && (M_stat == S_AOK) && (stat_out == S_AOK);

   // Memory is never reset; the write lands at the edge that retires M.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         for (int unsigned i = 0; i < 8; i++) begin
            mem[byte_idx[i]] <= M_valA[8*i +: 8];
         end
      end
   end

   assign bus.M_icode = M_icode;
   assign bus.M_dstE  = M_dstE;
   assign bus.M_dstM  = M_dstM;
   assign bus.M_valE  = M_valE;
   assign bus.M_Cnd   = M_Cnd;
   assign bus.m_valM  = (is_read && !addr_err) ? rd_data : '0;
   assign bus.m_stat  = stat_out;
   assign bus.m_valE  = M_valE;
   assign bus.m_dstE  = M_dstE;
   assign bus.m_dstM  = M_dstM;
   assign bus.m_icode = M_icode;
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus randomized traffic against
// a byte-array reference model. Honours MEM_ADDR_CHECK_EN like the design.
module tb_memory_stage;
   localparam int unsigned MEM_BYTES = 1024;

   typedef struct packed {
      logic [3:0]  icode;
      logic        cnd;
      logic [63:0] valE;
      logic [63:0] valA;
      logic [3:0]  dstE;
      logic [3:0]  dstM;
      logic [1:0]  stat;
   } minst_t;

   localparam minst_t BUBBLE = '{icode: 4'h0, cnd: 1'b0, valE: 64'h0, valA: 64'h0,
                                 dstE: 4'hF, dstM: 4'hF, stat: 2'b00};

   logic clk = 1'b0;
   logic reset = 1'b0;

   memory_stage_if mif ();

   memory_stage #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (mif)
   );

   always #5 clk = ~clk;

   minst_t      mm;
   logic [7:0]  ref_mem [MEM_BYTES];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   function automatic bit is_rd(logic [3:0] ic);
      return (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
   endfunction

   function automatic bit is_wr(logic [3:0] ic);
      return (ic == 4'h4) || (ic == 4'hA) || (ic == 4'h8);
   endfunction

   function automatic logic [63:0] eff_addr(minst_t m);
      return ((m.icode == 4'h5) || is_wr(m.icode)) ? m.valE : m.valA;
   endfunction

   function automatic bit bad_addr(minst_t m);
`ifdef MEM_ADDR_CHECK_EN
      return (is_rd(m.icode) || is_wr(m.icode)) && (eff_addr(m) > 64'(MEM_BYTES - 8));
`else
      return (m.icode == 4'hF) && (m.icode != 4'hF);
`endif
   endfunction

   function automatic logic [1:0] exp_stat(minst_t m);
      return bad_addr(m) ? 2'b10 : m.stat;
   endfunction

   function automatic logic [63:0] exp_valM(minst_t m);
      logic [63:0] v = '0;
      logic [63:0] a = eff_addr(m);
      if (!is_rd(m.icode) || bad_addr(m)) return '0;
      for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[int'((a + 64'(i)) % 64'(MEM_BYTES))];
      return v;
   endfunction

   task automatic drive(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                        input logic [3:0] de, input logic [3:0] dm, input logic [1:0] st);
      mif.e_icode = ic;
      mif.e_ifun  = 4'($urandom_range(0, 15));
      mif.e_Cnd   = 1'($urandom_range(0, 1));
      mif.e_valE  = ve;
      mif.e_valA  = va;
      mif.e_dstE  = de;
      mif.e_dstM  = dm;
      mif.e_stat  = st;
   endtask

   // Advance one cycle; the model retires the old M instruction, then loads the next.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         mm = BUBBLE;
      end else begin
         if (is_wr(mm.icode) && !mif.wr_block && mm.stat == 2'b00 && exp_stat(mm) == 2'b00)
            for (int i = 0; i < 8; i++)
               ref_mem[int'((mm.valE + 64'(i)) % 64'(MEM_BYTES))] = mm.valA[8*i +: 8];
         if (mif.M_bubble) mm = BUBBLE;
         else mm = '{icode: mif.e_icode, cnd: mif.e_Cnd, valE: mif.e_valE, valA: mif.e_valA,
                     dstE: mif.e_dstE, dstM: mif.e_dstM, stat: mif.e_stat};
      end
      #1;
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      mm = BUBBLE;
      #1;
      n_cmp++;
      if (mif.M_icode !== 4'h0 || mif.M_dstE !== 4'hF || mif.M_dstM !== 4'hF) begin
         n_bad++;
         $display("FAIL reset_mreg: got icode=%h dstE=%h dstM=%h, expected 0/F/F",
                  mif.M_icode, mif.M_dstE, mif.M_dstM);
      end
      n_cmp++;
      if (mif.m_stat !== 2'b00 || mif.m_valM !== 64'h0 || mif.m_valE !== 64'h0) begin
         n_bad++;
         $display("FAIL reset_mout: got stat=%b valM=%h valE=%h, expected 00/0/0",
                  mif.m_stat, mif.m_valM, mif.m_valE);
      end
      tick();
      tick();
      #2 reset = 1'b0;
      drive(4'h5, 64'h10, 64'h0, 4'hF, 4'h2, 2'b00);
      tick();
      n_cmp++;
      if (mif.m_valM !== 64'h0) begin
         n_bad++;
         $display("FAIL mem_zero_init: got %h, expected 0", mif.m_valM);
      end
   endtask

   task automatic test_rmmov_mrmov();
      drive(4'h4, 64'h40, 64'h1122334455667788, 4'hF, 4'hF, 2'b00);
      tick();
      drive(4'h5, 64'h40, 64'h0, 4'hF, 4'h3, 2'b00);
      tick();
      n_cmp++;
      if (mif.m_valM !== 64'h1122334455667788 || mif.m_dstM !== 4'h3) begin
         n_bad++;
         $display("FAIL mrmovq_0x40: got valM=%h dstM=%h, expected 1122334455667788/3",
                  mif.m_valM, mif.m_dstM);
      end
      drive(4'h5, 64'h41, 64'h0, 4'hF, 4'h3, 2'b00);
      tick();
      n_cmp++;
      if (mif.m_valM !== 64'h0011223344556677) begin
         n_bad++;
         $display("FAIL mrmovq_0x41_order: got %h, expected 0011223344556677", mif.m_valM);
      end
   endtask

   task automatic test_push_pop();
      drive(4'hA, 64'h100, 64'hABCD, 4'h4, 4'hF, 2'b00);
      tick();
      drive(4'hB, 64'h108, 64'h100, 4'h4, 4'h5, 2'b00);
      tick();
      n_cmp++;
      if (mif.m_valM !== 64'hABCD || mif.m_dstM !== 4'h5 || mif.m_dstE !== 4'h4 ||
          mif.m_valE !== 64'h108) begin
         n_bad++;
         $display("FAIL popq: got valM=%h dstM=%h dstE=%h valE=%h, expected ABCD/5/4/108",
                  mif.m_valM, mif.m_dstM, mif.m_dstE, mif.m_valE);
      end
      drive(4'h9, 64'h108, 64'h100, 4'h4, 4'hF, 2'b00);
      tick();
      n_cmp++;
      if (mif.m_valM !== 64'hABCD) begin
         n_bad++;
         $display("FAIL ret_read: got %h, expected ABCD", mif.m_valM);
      end
   endtask

   task automatic test_bubble();
      drive(4'h4, 64'hC0, 64'hDEAD, 4'h1, 4'h2, 2'b00);
      mif.M_bubble = 1'b1;
      tick();
      mif.M_bubble = 1'b0;
      n_cmp++;
      if (mif.M_icode !== 4'h0 || mif.M_dstE !== 4'hF || mif.M_dstM !== 4'hF ||
          mif.m_stat !== 2'b00 || mif.m_valM !== 64'h0) begin
         n_bad++;
         $display("FAIL bubble: got icode=%h dstE=%h dstM=%h stat=%b valM=%h",
                  mif.M_icode, mif.M_dstE, mif.M_dstM, mif.m_stat, mif.m_valM);
      end
      drive(4'h5, 64'hC0, 64'h0, 4'hF, 4'h1, 2'b00);
      tick();
      tick();
      n_cmp++;
      if (mif.m_valM !== 64'h0) begin
         n_bad++;
         $display("FAIL bubble_nowrite: got %h, expected 0", mif.m_valM);
      end
   endtask

   task automatic test_wr_suppress();
      drive(4'h4, 64'h80, 64'h5, 4'hF, 4'hF, 2'b00);
      tick();
      mif.wr_block = 1'b1;
      n_cmp++;
      if (mif.m_stat !== 2'b00) begin
         n_bad++;
         $display("FAIL wr_block_stat: got %b, expected 00", mif.m_stat);
      end
      drive(4'h4, 64'h88, 64'h77, 4'hF, 4'hF, 2'b01);
      tick();
      mif.wr_block = 1'b0;
      drive(4'h5, 64'h80, 64'h0, 4'hF, 4'h1, 2'b00);
      tick();
      n_cmp++;
      if (mif.m_valM !== 64'h0) begin
         n_bad++;
         $display("FAIL wr_block_nowrite: got %h, expected 0", mif.m_valM);
      end
      drive(4'h5, 64'h88, 64'h0, 4'hF, 4'h1, 2'b00);
      tick();
      n_cmp++;
      if (mif.m_valM !== 64'h0) begin
         n_bad++;
         $display("FAIL halt_stat_nowrite: got %h, expected 0", mif.m_valM);
      end
   endtask

   task automatic test_addr_edge();
      drive(4'h4, 64'h3F8, 64'h0102030405060708, 4'hF, 4'hF, 2'b00);
      tick();
      drive(4'h4, 64'h0, 64'h1112131415161718, 4'hF, 4'hF, 2'b00);
      tick();
      drive(4'h5, 64'h3F8, 64'h0, 4'hF, 4'h6, 2'b00);
      tick();
      n_cmp++;
      if (mif.m_valM !== 64'h0102030405060708 || mif.m_stat !== 2'b00) begin
         n_bad++;
         $display("FAIL last_ok_addr: got valM=%h stat=%b, expected 0102030405060708/00",
                  mif.m_valM, mif.m_stat);
      end
      drive(4'h5, 64'h3FC, 64'h0, 4'hF, 4'h6, 2'b00);
      tick();
`ifdef MEM_ADDR_CHECK_EN
      n_cmp++;
      if (mif.m_valM !== 64'h0 || mif.m_stat !== 2'b10) begin
         n_bad++;
         $display("FAIL adr_read: got valM=%h stat=%b, expected 0/10", mif.m_valM, mif.m_stat);
      end
      drive(4'h4, 64'h3FC, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 4'hF, 2'b00);
      tick();
      n_cmp++;
      if (mif.m_stat !== 2'b10) begin
         n_bad++;
         $display("FAIL adr_write_stat: got %b, expected 10", mif.m_stat);
      end
      drive(4'h5, 64'h3F8, 64'h0, 4'hF, 4'h6, 2'b00);
      tick();
      n_cmp++;
      if (mif.m_valM !== 64'h0102030405060708) begin
         n_bad++;
         $display("FAIL adr_write_dropped: got %h, expected 0102030405060708", mif.m_valM);
      end
`else
      n_cmp++;
      if (mif.m_valM !== 64'h1516171801020304 || mif.m_stat !== 2'b00) begin
         n_bad++;
         $display("FAIL wrap_read: got valM=%h stat=%b, expected 1516171801020304/00",
                  mif.m_valM, mif.m_stat);
      end
`endif
   endtask

   task automatic test_reset_mid();
      drive(4'h4, 64'h200, 64'h5555, 4'hF, 4'hF, 2'b00);
      tick();
      #2 reset = 1'b1;
      mm = BUBBLE;
      #1;
      n_cmp++;
      if (mif.M_icode !== 4'h0 || mif.m_stat !== 2'b00) begin
         n_bad++;
         $display("FAIL mid_reset: got icode=%h stat=%b, expected 0/00", mif.M_icode, mif.m_stat);
      end
      tick();
      #2 reset = 1'b0;
      drive(4'h5, 64'h200, 64'h0, 4'hF, 4'h1, 2'b00);
      tick();
      n_cmp++;
      if (mif.m_valM !== 64'h0) begin
         n_bad++;
         $display("FAIL mid_reset_nowrite: got %h, expected 0", mif.m_valM);
      end
   endtask

   function automatic logic [63:0] rand_addr();
      case ($urandom_range(0, 9))
         0:       return 64'(MEM_BYTES - 8 + $urandom_range(0, 7));
         1:       return {$urandom, $urandom};
         default: return 64'(32'h300 + 8 * $urandom_range(0, 15) + $urandom_range(0, 1) * 3);
      endcase
   endfunction

   task automatic test_random();
      for (int c = 0; c < 500; c++) begin
         drive(4'($urandom_range(0, 11)), rand_addr(), rand_addr(),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 9) < 8) ? 2'b00 : 2'($urandom_range(1, 3)));
         if ($urandom_range(0, 1)) mif.e_valA = {$urandom, $urandom};
         mif.wr_block = ($urandom_range(0, 99) < 15);
         mif.M_bubble = ($urandom_range(0, 99) < 10);
         tick();
         n_cmp++;
         if (mif.m_valM !== exp_valM(mm)) begin
            n_bad++;
            $display("FAIL rand_valM c%0d: got %h, expected %h", c, mif.m_valM, exp_valM(mm));
         end
         n_cmp++;
         if (mif.m_stat !== exp_stat(mm)) begin
            n_bad++;
            $display("FAIL rand_stat c%0d: got %b, expected %b", c, mif.m_stat, exp_stat(mm));
         end
         n_cmp++;
         if ({mif.m_icode, mif.m_dstE, mif.m_dstM, mif.m_valE, mif.M_Cnd} !==
             {mm.icode, mm.dstE, mm.dstM, mm.valE, mm.cnd}) begin
            n_bad++;
            $display("FAIL rand_pass c%0d: got %h/%h/%h/%h/%b, expected %h/%h/%h/%h/%b", c,
                     mif.m_icode, mif.m_dstE, mif.m_dstM, mif.m_valE, mif.M_Cnd,
                     mm.icode, mm.dstE, mm.dstM, mm.valE, mm.cnd);
         end
      end
      mif.wr_block = 1'b0;
      mif.M_bubble = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'h00;
      mm = BUBBLE;
      mif.M_bubble = 1'b0;
      mif.wr_block = 1'b0;
      drive(4'h0, 64'h0, 64'h0, 4'hF, 4'hF, 2'b00);
      test_reset();
      test_rmmov_mrmov();
      test_push_pop();
      test_bubble();
      test_wr_suppress();
      test_addr_edge();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter MEM_BYTES, default 1024, data-memory size in bytes.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 e_icode, e_ifun  in  4 each  instruction code and function from execute.
REQ-005 e_Cnd  in  1  condition result from execute.
REQ-006 e_valE, e_valA  in  64 each  ALU result and operand A from execute.
REQ-007 e_dstE, e_dstM  in  4 each  destination registers; 4'hF = none.
REQ-008 e_stat  in  2  status: 00 AOK, 01 HLT, 10 ADR, 11 INS.
REQ-009 M_bubble  in  1  load bubble into M register at next edge.
REQ-010 wr_block  in  1  suppress memory write this cycle; driven by control on a downstream exception.
REQ-011 M_icode, M_dstE, M_dstM  out  4 each  M-register contents, exported for forwarding and control.
REQ-012 M_valE  out  64  M-register valE, exported for forwarding.
REQ-013 M_Cnd  out  1  M-register condition.
REQ-014 m_valM  out  64  memory read data.
REQ-015 m_stat  out  2  stage status after memory check.
REQ-016 m_valE, m_dstE, m_dstM, m_icode  out  64/4/4/4  pass-through of M register to writeback.

Function
REQ-017 At each rising clk, the M register SHALL capture e_icode, e_Cnd, e_valE, e_valA, e_dstE, e_dstM and e_stat, unless M_bubble=1.
REQ-018 When M_bubble=1 at a rising edge, the M register SHALL load bubble values: icode 0, Cnd 0, valE 0, valA 0, dstE F, dstM F, stat AOK.
REQ-019 All m_* outputs SHALL be combinational from the M register and memory, giving 1-cycle latency from e_* to m_*.
REQ-020 Read instructions SHALL read 8 bytes little-endian, combinationally: mrmovq (5) at M_valE; popq (B) and ret (9) at M_valA.
REQ-021 Write instructions SHALL write M_valA as 8 bytes little-endian at the rising edge that ends the M cycle: rmmovq (4), pushq (A) and call (8), each at address M_valE.
REQ-022 For non-read instructions, m_valM SHALL be 0.
REQ-023 The write SHALL be suppressed when any of these holds: wr_block=1, M_stat≠AOK, or m_stat≠AOK.
REQ-024 A read in cycle N+1 SHALL return data written by the instruction in M during cycle N.
REQ-025 m_stat SHALL equal M_stat unless an address error occurs (see REQ-031).
REQ-026 A bubble in M SHALL produce no memory access and m_stat=AOK.
REQ-027 Memory contents SHALL be zero at time 0.

Reset
REQ-028 While reset=1, the M register SHALL hold bubble values asynchronously, overriding clk and M_bubble.
REQ-029 Reset SHALL NOT alter memory contents, and no write SHALL occur at an edge where reset=1.
REQ-030 If reset is asserted mid-cycle, a pending write SHALL be dropped, and m_* outputs SHALL reflect the bubble immediately.

Configuration
REQ-031 When MEM_ADDR_CHECK_EN is defined, an access with address > MEM_BYTES-8 (unsigned 64-bit compare) SHALL force m_stat=ADR (10), force m_valM=0, and suppress the write.
REQ-032 When MEM_ADDR_CHECK_EN is undefined, each byte address SHALL wrap modulo MEM_BYTES, and m_stat SHALL always equal M_stat.

Verification
REQ-033 rmmovq: e_icode=4, e_valE=0x40, e_valA=0x1122334455667788 -> after the edge, the bytes at 0x40..0x47 are 88,77,...,11; the next-cycle mrmovq at 0x40 gives m_valM=0x1122334455667788.
REQ-034 pushq then popq: pushq with valE=0x100, valA=0xABCD, then popq with valA=0x100 -> m_valM=0xABCD, m_dstM=e_dstM of the popq.
REQ-035 Bubble: M_bubble=1 while e_icode=4 -> M_icode=0, M_dstE=F, M_dstM=F, no write (memory unchanged).
REQ-036 wr_block=1 with rmmovq to 0x80, data 0x5 -> the bytes at 0x80 stay 0; m_stat=AOK.
REQ-037 With MEM_ADDR_CHECK_EN defined: mrmovq valE=0x3FC (MEM_BYTES=1024) -> m_stat=10, m_valM=0. Undefined: the same access reads bytes 0x3FC..0x3FF and 0x000..0x003.
REQ-038 Assert reset mid-cycle with rmmovq in M -> M_icode=0 immediately, no write, m_stat=AOK.
